compli_pair_driver: RTL and testbench
=====================================

// Module: compli_pair_driver
// PURPOSE
//  Transmit side of the complementary-pair (p/n) safety signalling. Encodes a
//  single on/off request onto a registered 2-bit pair: ACTIVE = {p,n}=10,
//  SAFE = 01. Periodically injects OSSD-style test pulses (SAFE) while active.
//  Checks the pin readback against the delayed command and latches a fault
//  that forces SAFE. Sits between safety logic and the digital output pins.
// PARAMETERS
//  TEST_PERIOD   10000  ACTIVE cycles between test pulses (>=2)
//  TEST_WIDTH    8      test pulse length in cycles (>= FAULT_FILTER+RB_DELAY)
//  RB_DELAY      2      pipeline depth from pn_o to pn_rb_i (>=1)
//  FAULT_FILTER  3      consecutive mismatch cycles that latch a fault (>=1)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  req_on_i     in   1  1 = request ACTIVE output
//  fault_clr_i  in   1  single-cycle fault clear request
//  pn_rb_i      in   2  readback pair {p,n}
//  pn_o         out  2  driven pair {p,n}
//  active_o     out  1  1 while state==ACTIVE
//  test_o       out  1  1 while state==TEST
//  fault_o      out  1  1 while state==FAULT
//  state_o      out  2  SAFE=0, ACTIVE=1, TEST=2, FAULT=3
// BEHAVIOUR
//  - Reset (async assert, sync release): state=SAFE, pn_o=01, active_o=0,
//    test_o=0, fault_o=0, all counters=0, command delay line filled with 01.
//  - pn_o is one register, decoded from next-state: 10 only in ACTIVE, 01 in
//    every other state. pn_o never shows 00 or 11; both bits change together.
//  - Transitions, evaluated each cycle. Priority: fault > clear > req:
//    SAFE->ACTIVE on req_on_i=1. Output is 10 on the first edge after req.
//    ACTIVE->SAFE on req_on_i=0, which also clears the period counter.
//    ACTIVE->TEST when the period counter reaches TEST_PERIOD-1. Counter reset.
//    TEST->ACTIVE or SAFE (per req_on_i) after exactly TEST_WIDTH cycles.
//    req_on_i=0 during TEST does not shorten the pulse.
//    any->FAULT when the mismatch counter reaches FAULT_FILTER. Sticky.
//    FAULT->SAFE only if fault_clr_i=1 && req_on_i=0 && pn_rb_i==01 in the
//    same cycle. Otherwise the clear is ignored (not remembered).
//  - Readback check: cmd_dly = pn_o delayed RB_DELAY cycles. Mismatch when
//    pn_rb_i!=cmd_dly. This includes rb p==n (00/11), which always mismatches.
//    Mismatch counter: +1 on mismatch, saturates at FAULT_FILTER. Cleared on
//    any match.
//  - Compare masked for the first RB_DELAY cycles after reset release.
//  - In FAULT the counter is held at 0. The compare continues only for the
//    clear qualification (raw pn_rb_i==01).
//  - Simultaneous: fault detection in the same cycle as a req change or
//    TEST_PERIOD expiry goes to FAULT. Reset mid-pulse returns to SAFE/01
//    immediately (async).
//  - Period counter width $clog2(TEST_PERIOD). Pulse counter width
//    $clog2(TEST_WIDTH+1). No wrap: both are reset on terminal count.
// TESTING (TEST_PERIOD=20, TEST_WIDTH=8, RB_DELAY=2, FAULT_FILTER=3)
//  1. Reset with rb=xx -> pn_o=01, state_o=0, fault_o=0. No fault in first
//     2 cycles.
//  2. Loopback rb=pn_o delayed 2; req_on_i 0->1 at cycle N -> pn_o=10 at N+1,
//     active_o=1, fault_o never asserts.
//  3. Hold req on with loopback -> pn_o=01 for exactly 8 cycles after every
//     20 ACTIVE cycles (28-cycle period), test_o aligned, no fault.
//  4. rb stuck at 10 through a test pulse -> fault_o=1 3 cycles after the
//     first mismatch. pn_o=01 and held with req on.
//  5. rb=11 for 2 cycles then correct -> no fault. rb=11 for 3 cycles ->
//     FAULT, pn_o=01.
//  6. In FAULT: clr with req_on=1 -> stays FAULT. clr with req_on=0 and rb=10
//     -> stays. clr with req_on=0 and rb=01 -> SAFE next cycle, fault_o=0.

Source files
------------

// File: rtl/compli_pair_driver.sv
// Complementary-pair (p/n) safety output driver.
// Test pulses while active, readback check, sticky fault forcing SAFE.
module compli_pair_driver #(
  parameter int TEST_PERIOD  = 10000,
  parameter int TEST_WIDTH   = 8,
  parameter int RB_DELAY     = 2,
  parameter int FAULT_FILTER = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_on_i,
  input  logic       fault_clr_i,
  input  logic [1:0] pn_rb_i,
  output logic [1:0] pn_o,
  output logic       active_o,
  output logic       test_o,
  output logic       fault_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_SAFE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_TEST   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  localparam int PW = $clog2(TEST_PERIOD);
  localparam int WW = $clog2(TEST_WIDTH + 1);
  localparam int FW = $clog2(FAULT_FILTER + 1);
  localparam int MW = $clog2(RB_DELAY + 1);

  localparam logic [PW-1:0] PER_LAST = PW'(TEST_PERIOD - 1);
  localparam logic [WW-1:0] PUL_LAST = WW'(TEST_WIDTH - 1);
  localparam logic [FW-1:0] MIS_MAX  = FW'(FAULT_FILTER);
  localparam logic [FW-1:0] MIS_TRIP = FW'(FAULT_FILTER - 1);
  localparam logic [MW-1:0] MASK_END = MW'(RB_DELAY);

  localparam logic [1:0] PN_ACT  = 2'b10;
  localparam logic [1:0] PN_SAFE = 2'b01;

  state_t        state, nxt;
  logic [PW-1:0] per_cnt, per_nxt;
  logic [WW-1:0] pul_cnt, pul_nxt;
  logic [FW-1:0] mis_cnt, mis_nxt;
  logic [MW-1:0] mask_cnt;
  logic [1:0]    dly [RB_DELAY];
  logic [1:0]    pn_nxt;
  logic          cmp_en;
  logic          mismatch;
  logic          fault_det;
  logic          clr_ok;

  assign cmp_en    = (mask_cnt == MASK_END);
  assign mismatch  = cmp_en && (pn_rb_i != dly[RB_DELAY-1]);
  assign fault_det = mismatch && (mis_cnt >= MIS_TRIP)
                     && (state != S_FAULT);
  assign clr_ok    = fault_clr_i && !req_on_i && (pn_rb_i == PN_SAFE);

  // next state, counters and the pair encoding
  always_comb begin
    nxt     = state;
    per_nxt = '0;
    pul_nxt = '0;
    mis_nxt = '0;
    if (fault_det) begin
      nxt = S_FAULT;
    end else begin
      case (state)
        S_SAFE:   if (req_on_i) nxt = S_ACTIVE;
        S_ACTIVE: begin
          if (!req_on_i)             nxt = S_SAFE;
          else if (per_cnt == PER_LAST) nxt = S_TEST;
        end
        S_TEST: begin
          if (pul_cnt == PUL_LAST)
            nxt = req_on_i ? S_ACTIVE : S_SAFE;
        end
        S_FAULT:  if (clr_ok) nxt = S_SAFE;
        default:  nxt = S_FAULT;
      endcase
    end
    if (state == S_ACTIVE && nxt == S_ACTIVE)
      per_nxt = per_cnt + 1'b1;
    if (state == S_TEST && nxt == S_TEST)
      pul_nxt = pul_cnt + 1'b1;
    if (state != S_FAULT && nxt != S_FAULT && mismatch)
      mis_nxt = (mis_cnt == MIS_MAX) ? mis_cnt
                                     : mis_cnt + 1'b1;
    pn_nxt = (nxt == S_ACTIVE) ? PN_ACT : PN_SAFE;
  end

  // state, counters and the registered pin pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_SAFE;
      per_cnt <= '0;
      pul_cnt <= '0;
      mis_cnt <= '0;
      pn_o    <= PN_SAFE;
    end else begin
      state   <= nxt;
      per_cnt <= per_nxt;
      pul_cnt <= pul_nxt;
      mis_cnt <= mis_nxt;
      pn_o    <= pn_nxt;
    end
  end

  // command delay line matching the pin readback latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RB_DELAY; i++)
        dly[i] <= PN_SAFE;
    end else begin
      dly[0] <= pn_o;
      for (int i = 1; i < RB_DELAY; i++)
        dly[i] <= dly[i-1];
    end
  end

  // compare blanking until the delay line holds real commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mask_cnt <= '0;
    else if (!cmp_en)
      mask_cnt <= mask_cnt + 1'b1;
  end

  assign active_o = (state == S_ACTIVE);
  assign test_o   = (state == S_TEST);
  assign fault_o  = (state == S_FAULT);
  assign state_o  = state;

endmodule

// File: tb/tb_compli_pair_driver.sv
// Directed bench for compli_pair_driver.
// Loopback readback with forced overrides.
module tb_compli_pair_driver;

  logic       clk;
  logic       rst_n;
  logic       req_on;
  logic       fault_clr;
  logic [1:0] pn_rb;
  logic [1:0] pn;
  logic       active;
  logic       test;
  logic       fault;
  logic [1:0] state;

  logic       rb_force;
  logic [1:0] rb_val;
  logic [1:0] lb1, lb2;

  int errors = 0;
  int checks = 0;

  compli_pair_driver #(
    .TEST_PERIOD (20),
    .TEST_WIDTH  (8),
    .RB_DELAY    (2),
    .FAULT_FILTER(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_on_i   (req_on),
    .fault_clr_i(fault_clr),
    .pn_rb_i    (pn_rb),
    .pn_o       (pn),
    .active_o   (active),
    .test_o     (test),
    .fault_o    (fault),
    .state_o    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pin loopback: pn delayed two cycles
  always @(posedge clk) begin
    lb1 <= pn;
    lb2 <= lb1;
  end

  assign pn_rb = rb_force ? rb_val : lb2;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_on    = 1'b0;
    fault_clr = 1'b0;
    rb_force  = 1'b1;
    rb_val    = 2'bxx;
    repeat (4) tick();
    chk("rst_pn", {2'b0, pn}, 4'h1);
    chk("rst_state", {2'b0, state}, 4'h0);
    chk("rst_fault", {3'b0, fault}, 4'h0);
    rst_n = 1'b1;
    tick();
    chk("mask_c1_fault", {3'b0, fault}, 4'h0);
    tick();
    chk("mask_c2_fault", {3'b0, fault}, 4'h0);
    chk("mask_c2_state", {2'b0, state}, 4'h0);
    rb_force = 1'b0;
    repeat (3) tick();
    chk("idle_state", {2'b0, state}, 4'h0);

    // request on, two full period/pulse rounds
    req_on = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 20; j++) begin
        tick();
        chk("act_pn", {2'b0, pn}, 4'h2);
        chk("act_flags", {1'b0, active, test, fault}, 4'h4);
      end
      for (int k = 0; k < 8; k++) begin
        tick();
        chk("tst_pn", {2'b0, pn}, 4'h1);
        chk("tst_flags", {1'b0, active, test, fault}, 4'h2);
        chk("tst_state", {2'b0, state}, 4'h2);
      end
    end

    // readback stuck at 10 across the next pulse
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("act3_pn", {2'b0, pn}, 4'h2);
    end
    rb_force = 1'b1;
    rb_val   = 2'b10;
    for (int j = 5; j < 20; j++) begin
      tick();
      chk("stuck_act", {1'b0, active, test, fault}, 4'h4);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stuck_tst", {1'b0, active, test, fault}, 4'h2);
    end
    tick();
    chk("stuck_fault", {1'b0, active, test, fault}, 4'h1);
    chk("stuck_state", {2'b0, state}, 4'h3);
    chk("stuck_pn", {2'b0, pn}, 4'h1);
    repeat (3) tick();
    chk("fault_hold_pn", {2'b0, pn}, 4'h1);
    chk("fault_hold", {3'b0, fault}, 4'h1);

    // clear qualification
    rb_val    = 2'b01;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_req_on", {2'b0, state}, 4'h3);
    req_on    = 1'b0;
    rb_val    = 2'b10;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_rb10", {2'b0, state}, 4'h3);
    rb_val = 2'b01;
    tick();
    chk("clr_not_kept", {2'b0, state}, 4'h3);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_ok_state", {2'b0, state}, 4'h0);
    chk("clr_ok_fault", {3'b0, fault}, 4'h0);
    chk("clr_ok_pn", {2'b0, pn}, 4'h1);
    rb_force = 1'b0;
    tick();
    chk("safe_stay", {2'b0, state}, 4'h0);

    // short 11 glitch filtered, long one latches
    req_on = 1'b1;
    repeat (3) tick();
    chk("re_act", {2'b0, pn}, 4'h2);
    rb_force = 1'b1;
    rb_val   = 2'b11;
    repeat (2) tick();
    rb_force = 1'b0;
    tick();
    chk("glitch2_fault", {3'b0, fault}, 4'h0);
    tick();
    chk("glitch2_state", {2'b0, state}, 4'h1);
    rb_force = 1'b1;
    repeat (2) tick();
    chk("glitch3_pre", {3'b0, fault}, 4'h0);
    tick();
    chk("glitch3_fault", {3'b0, fault}, 4'h1);
    chk("glitch3_pn", {2'b0, pn}, 4'h1);
    rb_force = 1'b0;

    // asynchronous reset while active
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("ar_pre", {2'b0, pn}, 4'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pn", {2'b0, pn}, 4'h1);
    chk("ar_state", {2'b0, state}, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
